// File: rtl/ahb_bridge_arbiter.sv
// Shares the AHB-to-APB bridge slave port between NUM_MASTERS AHB masters.
// Round-robin by default; define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module ahb_bridge_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_BEATS   = 4
) (
  input  logic                          hclk,
  input  logic                          hresetn,
  input  logic [NUM_MASTERS-1:0]        hbusreq,
  output logic [NUM_MASTERS-1:0]        hgrant,
  output logic [1:0]                    hmaster,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_haddr,
  input  logic [NUM_MASTERS*2-1:0]      m_htrans,
  input  logic [NUM_MASTERS-1:0]        m_hwrite,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_hwdata,
  input  logic                          hready,
  output logic [ADDR_W-1:0]             haddr,
  output logic [1:0]                    htrans,
  output logic                          hwrite,
  output logic [DATA_W-1:0]             hwdata,
  output logic                          hready_in
);

  localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t              state;
  logic [1:0]          hmaster_d;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [ADDR_W-1:0]   sel_addr;
  logic [1:0]          sel_trans;
  logic                sel_write;
  logic [DATA_W-1:0]   sel_wdata;
  logic                owner_req;
  logic                at_limit;
  logic                rearb;
  logic [1:0]          search_start;
  logic                win_found;
  logic [1:0]          winner;
`ifndef ARB_FIXED_PRIO_EN
  logic [1:0]          rr_ptr;
`endif

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (int'(idx) >= NUM_MASTERS - 1) ? 2'd0 : idx + 2'd1;
  endfunction

  // Address/control follow the address-phase owner, write data the data-phase owner.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_addr  = m_haddr[ADDR_W-1:0];
    sel_trans = m_htrans[1:0];
    sel_write = m_hwrite[0];
    owner_req = hbusreq[0];
    sel_wdata = m_hwdata[DATA_W-1:0];
    for (int i = 1; i < NUM_MASTERS; i++) begin
      if (hmaster == 2'(i)) begin
        sel_addr  = m_haddr[i*ADDR_W +: ADDR_W];
        sel_trans = m_htrans[i*2 +: 2];
        sel_write = m_hwrite[i];
        owner_req = hbusreq[i];
      end
      if (hmaster_d == 2'(i)) sel_wdata = m_hwdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    at_limit = (beat_cnt == LAST_BEAT);
    rearb    = !owner_req;
`ifdef ARB_FIXED_PRIO_EN
    if (at_limit && |(hbusreq & (hgrant - NUM_MASTERS'(1)))) rearb = 1'b1;
    search_start = 2'd0;
`else
    if (at_limit && |(hbusreq & ~hgrant)) rearb = 1'b1;
    search_start = (state == IDLE) ? rr_ptr : next_idx(hmaster);
`endif
  end

  // Circular search: first pass covers [start, N-1], second pass wraps to [0, start-1].
  always_comb begin
    win_found = 1'b0;
    winner    = 2'd0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (!win_found && hbusreq[j] && (2'(j) >= search_start)) begin
        win_found = 1'b1;
        winner    = 2'(j);
      end
    end
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (!win_found && hbusreq[j]) begin
        win_found = 1'b1;
        winner    = 2'(j);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= IDLE;
      hgrant    <= '0;
      hmaster   <= 2'd0;
      hmaster_d <= 2'd0;
      beat_cnt  <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr    <= 2'd0;
`endif
    end else if (hready) begin
      hmaster_d <= hmaster;
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= OWNED;
            hgrant   <= NUM_MASTERS'(1) << winner;
            hmaster  <= winner;
            beat_cnt <= '0;
          end
        end
        OWNED: begin
          if (rearb) begin
            beat_cnt <= '0;
            if (win_found) begin
              hgrant  <= NUM_MASTERS'(1) << winner;
              hmaster <= winner;
`ifndef ARB_FIXED_PRIO_EN
              rr_ptr  <= next_idx(winner);
`endif
            end else begin
              state  <= IDLE;
              hgrant <= '0;
            end
          end else if (at_limit) begin
            // Sole requester at the beat limit keeps the bus with a fresh count.
            beat_cnt <= '0;
          end else if (sel_trans[1]) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign haddr     = sel_addr;
  assign htrans    = (state == OWNED) ? sel_trans : 2'b00;
  assign hwrite    = sel_write;
  assign hwdata    = sel_wdata;
  assign hready_in = hready;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Self-checking bench for ahb_bridge_arbiter: directed scenarios plus randomized
// traffic compared against a tenure-level reference model.
module tb_ahb_bridge_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;

  logic              hclk = 1'b0;
  logic              hresetn;
  logic [NM-1:0]     hbusreq;
  logic [NM-1:0]     hgrant;
  logic [1:0]        hmaster;
  logic [NM*AW-1:0]  m_haddr;
  logic [NM*2-1:0]   m_htrans;
  logic [NM-1:0]     m_hwrite;
  logic [NM*DW-1:0]  m_hwdata;
  logic              hready;
  logic [AW-1:0]     haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [DW-1:0]     hwdata;
  logic              hready_in;

  logic [AW-1:0]     addr_a  [NM];
  logic [1:0]        trans_a [NM];
  logic [DW-1:0]     wdata_a [NM];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: current owner (-1 when idle), transfers counted in this tenure.
  int owner, hm, hmd, beats, rr;

  ahb_bridge_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .MAX_BEATS(MB)) dut (
    .hclk(hclk), .hresetn(hresetn), .hbusreq(hbusreq), .hgrant(hgrant), .hmaster(hmaster),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hwdata(m_hwdata),
    .hready(hready), .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata),
    .hready_in(hready_in)
  );

  always #5 hclk = ~hclk;

  always_comb begin
    m_haddr  = '0;
    m_htrans = '0;
    m_hwdata = '0;
    for (int i = 0; i < NM; i++) begin
      m_haddr[i*AW +: AW]  = addr_a[i];
      m_htrans[i*2 +: 2]   = trans_a[i];
      m_hwdata[i*DW +: DW] = wdata_a[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic int find_winner(input logic [NM-1:0] req, input int start);
    for (int i = 0; i < NM; i++) begin
      int j;
      j = (start + i) % NM;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1; hm = 0; hmd = 0; beats = 0; rr = 0;
  endtask

  task automatic model_update();
    int  w;
    bit  contender;
    if (!hready) return;
    hmd = hm;
    if (owner < 0) begin
`ifdef ARB_FIXED_PRIO_EN
      w = find_winner(hbusreq, 0);
`else
      w = find_winner(hbusreq, rr);
`endif
      if (w >= 0) begin owner = w; hm = w; beats = 0; end
    end else begin
      contender = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
      for (int j = 0; j < owner; j++) if (hbusreq[j]) contender = 1'b1;
`else
      for (int j = 0; j < NM; j++) if (j != owner && hbusreq[j]) contender = 1'b1;
`endif
      if (!hbusreq[owner] || (beats == MB - 1 && contender)) begin
`ifdef ARB_FIXED_PRIO_EN
        w = find_winner(hbusreq, 0);
`else
        w = find_winner(hbusreq, (owner + 1) % NM);
`endif
        beats = 0;
        if (w >= 0) begin owner = w; hm = w; rr = (w + 1) % NM; end
        else owner = -1;
      end else if (beats == MB - 1) begin
        beats = 0;
      end else if (trans_a[owner][1]) begin
        beats++;
      end
    end
  endtask

  task automatic model_check();
    logic [NM-1:0] eg;
    eg = (owner < 0) ? '0 : (NM'(1) << owner);
    check("hgrant", 64'(hgrant), 64'(eg));
    check("hmaster", 64'(hmaster), 64'(hm));
    check("htrans", 64'(htrans), (owner < 0) ? 64'd0 : 64'(trans_a[hm]));
    check("haddr", 64'(haddr), 64'(addr_a[hm]));
    check("hwrite", 64'(hwrite), 64'(m_hwrite[hm]));
    check("hwdata", 64'(hwdata), 64'(wdata_a[hmd]));
    check("hready_in", 64'(hready_in), 64'(hready));
  endtask

  // One clock: DUT and model advance on the edge, outputs checked mid-cycle.
  task automatic tick();
    @(posedge hclk);
    model_update();
    @(negedge hclk);
    #1;
    model_check();
  endtask

  task automatic apply_reset();
    hresetn = 1'b0;
    model_reset();
    #1;
    check("rst_hgrant", 64'(hgrant), 64'd0);
    check("rst_htrans", 64'(htrans), 64'd0);
    check("rst_hmaster", 64'(hmaster), 64'd0);
    #1;
    hresetn = 1'b1;
  endtask

  initial begin
    int waited;
    hresetn = 1'b0;
    hready  = 1'b1;
    hbusreq = '0;
    m_hwrite = '0;
    for (int i = 0; i < NM; i++) begin
      addr_a[i]  = 32'h1000_0000 * (i + 1);
      trans_a[i] = 2'b10;
      wdata_a[i] = 32'h0000_1111 * (i + 1);
    end
    model_reset();
    #22;
    check("reset_hgrant", 64'(hgrant), 64'd0);
    check("reset_hmaster", 64'(hmaster), 64'd0);
    check("reset_htrans", 64'(htrans), 64'd0);
    check("reset_haddr_m0", 64'(haddr), 64'(addr_a[0]));
    hresetn = 1'b1;

`ifdef ARB_FIXED_PRIO_EN
    hbusreq = 3'b110;
    tick();
    check("fp_first_grant", 64'(hgrant), 64'b010);
    hbusreq = 3'b111;
    waited = 0;
    while (hgrant != 3'b001 && waited < 8) begin
      tick();
      waited++;
      check("fp_m2_never", 64'(hgrant[2]), 64'd0);
    end
    check("fp_preempt_in_budget", 64'(waited <= MB), 64'd1);
`else
    // All masters requesting with continuous NONSEQ: MB transfers each, in order.
    hbusreq = 3'b111;
    for (int i = 0; i < 13; i++) begin
      tick();
      check("rotation", 64'(hmaster), 64'((i / MB) % NM));
    end
`endif
    @(negedge hclk);
    #1;
    apply_reset();

    // Single request from master 1.
    hbusreq = 3'b010;
    tick();
    check("m1_hgrant", 64'(hgrant), 64'b010);
    check("m1_hmaster", 64'(hmaster), 64'd1);
    check("m1_haddr", 64'(haddr), 64'h2000_0000);
    tick();
    check("m1_hwdata", 64'(hwdata), 64'h0000_2222);

    // Owner 0, then wait states with a pending switch.
    hbusreq = 3'b001;
    tick();
    check("own0_hgrant", 64'(hgrant), 64'b001);
    tick();
    hbusreq = 3'b110;
    hready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze_hgrant", 64'(hgrant), 64'b001);
      check("freeze_hmaster", 64'(hmaster), 64'd0);
    end
    hready = 1'b1;
    tick();
    check("unfreeze_hgrant", 64'(hgrant), 64'b010);

    // Write data of the last address phase stays with the previous owner.
    hbusreq = 3'b001;
    tick();
    m_hwrite   = 3'b001;
    wdata_a[0] = 32'hA5A5_A5A5;
    wdata_a[2] = 32'h5A5A_5A5A;
    hbusreq    = 3'b100;
    tick();
    check("switch_hmaster", 64'(hmaster), 64'd2);
    check("switch_hwdata_prev", 64'(hwdata), 64'hA5A5_A5A5);
    tick();
    check("switch_hwdata_new", 64'(hwdata), 64'h5A5A_5A5A);

    // Requests drop: back to idle with htrans forced IDLE.
    hbusreq = 3'b000;
    tick();
    check("idle_hgrant", 64'(hgrant), 64'd0);
    check("idle_htrans", 64'(htrans), 64'd0);

    // Asynchronous reset in the middle of a transfer.
    hbusreq = 3'b001;
    tick();
    check("pre_rst_htrans", 64'(htrans), 64'b10);
    apply_reset();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NM; i++) begin
        if ($urandom_range(7) == 0) hbusreq[i] = ~hbusreq[i];
        trans_a[i]  = 2'($urandom_range(3));
        addr_a[i]   = $urandom;
        wdata_a[i]  = $urandom;
        m_hwrite[i] = 1'($urandom_range(1));
      end
      hready = ($urandom_range(4) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
